// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory req/ack, core valid/ready and redirect.
// master = fetch queue side, slave = memory/core side.
interface instr_fetch_queue_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              ir_valid;
  logic [31:0]       ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output ir_valid, ir_data, ir_pc,
    input  ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  ir_valid, ir_data, ir_pc,
    output ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one-outstanding word fetches into a small {pc, instr} FIFO with redirect flush.
// Optional IFQ_BYPASS_EN: an ack into an empty FIFO is presented to the core in the same cycle.
module instr_fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 CLK,
  input logic                 RST_N,
  instr_fetch_queue_if.master bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic [ADDR_W-1:0] redirect_base;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  entry_t            mem [DEPTH];
  entry_t            head;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ack_live;
  logic              push;
  logic              pop;
  logic              issue;
`ifdef IFQ_BYPASS_EN
  logic              bypass;
`endif

  // Issue decision uses the occupancy after this cycle's push/pop so an ack never lands on a full FIFO.
  always_comb begin
    fetch_pc_inc  = fetch_pc + ADDR_W'(4);
    redirect_base = bus.redirect_pc & ~ADDR_W'(3);
    ack_live      = (state == WAIT) && bus.imem_ack && !bus.redirect;
    pop           = (count != '0) && bus.ir_ready;
`ifdef IFQ_BYPASS_EN
    bypass        = (count == '0) && ack_live;
    push          = ack_live && !(bypass && bus.ir_ready);
`else
    push          = ack_live;
`endif
    count_next    = count + CNT_W'(push) - CNT_W'(pop);
    issue         = count_next < CNT_W'(DEPTH);
  end

  // Request FSM; redirect overrides everything but reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= redirect_base;
      if (state != IDLE && !bus.imem_ack) begin
        state <= DISCARD;
      end else begin
        state <= IDLE;
        req_q <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state  <= WAIT;
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            fetch_pc <= fetch_pc_inc;
            if (issue) begin
              addr_q <= fetch_pc_inc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (bus.imem_ack) begin
            if (issue) begin
              state  <= WAIT;
              addr_q <= fetch_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage and occupancy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_rdata};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;

`ifdef IFQ_BYPASS_EN
  assign bus.ir_valid = (count != '0) || bypass;
  assign bus.ir_data  = bypass ? bus.imem_rdata : head.instr;
  assign bus.ir_pc    = bypass ? fetch_pc : head.pc;
`else
  assign bus.ir_valid = (count != '0);
  assign bus.ir_data  = head.instr;
  assign bus.ir_pc    = head.pc;
`endif

endmodule
